photo_pixel_pipe: RTL and testbench
===================================

// Module: photo_pixel_pipe
// PURPOSE
// Parametrised pixel pipeline between the QSPI DTR flash reader and the VGA output stage. Per display row it:
//   - issues the flash line read;
//   - buffers returned bytes in a small FIFO;
//   - unpacks them per colour mode (8bpp direct, 4bpp palette, 2bpp grey);
//   - replicates pixels horizontally/vertically by powers of two;
//   - drives registered RGB.
// It is the generalised successor of the fixed 8bpp / 2x-vertical fetch path in the photo frame top level.
//
// PARAMETERS
// ADDR_W     24  flash byte address width
// COL_W      11  width of line_bytes
// FIFO_DEPTH 4   byte FIFO entries, power of two, >=2
// CHAN_BITS  2   bits per colour channel output, >=2
//
// PORTS
// clk          in   1               clock
// rst_n        in   1               synchronous active-low reset
// frame_base   in   ADDR_W          image start address, sampled on frame_pulse
// line_bytes   in   COL_W           bytes per source line (address stride)
// mode         in   2               0=8bpp direct, 1=4bpp palette, 2=2bpp grey, 3=reserved (behaves as 0)
// hscale       in   2               log2 horizontal replication 0..2 (3 treated as 2)
// vscale       in   2               log2 vertical replication 0..2 (3 treated as 2)
// row_pulse    in   1               1-cycle pulse at start of each display row
// frame_pulse  in   1               1-cycle pulse at start of frame
// active       in   1               display active region
// pal_we       in   1               palette write strobe
// pal_addr     in   4               palette index
// pal_data     in   3*CHAN_BITS     palette entry {B,G,R}
// start_read   out  1               1-cycle read request to flash reader
// addr_out     out  ADDR_W          read address, valid while start_read=1
// stop_read    out  1               1-cycle pulse on active falling edge
// byte_in      in   8               byte from flash reader
// byte_valid   in   1               byte_in valid (no backpressure)
// R, G, B      out  CHAN_BITS each  registered colour
// overflow     out  1               sticky: byte arrived with FIFO full
// underflow    out  1               sticky: pixel needed with FIFO empty
//
// BEHAVIOUR
// Reset:
//   - all outputs 0; FIFO empty; line_addr=0; rep_cnt=0.
//   - The palette is NOT reset; contents are undefined until written.
// Frame pulse:
//   - line_addr<=frame_base; rep_cnt<=0.
// Row pulse:
//   - FIFO and unpacker flushed; a byte_valid in the same cycle is dropped and does not count as overflow.
//   - Next cycle: start_read=1, addr_out=line_addr.
//   - Rows whose line_addr advance is pending use the new address.
//   - rep_cnt counts rows mod 2^vscale. When it wraps, line_addr+=line_bytes, zero-extended, mod 2^ADDR_W.
//   - Row and frame pulses in the same cycle: the frame pulse wins. addr_out=frame_base and no stride is applied.
// FIFO:
//   - A push on byte_valid while full drops the byte and sets overflow.
//   - A pop and a push in the same cycle while full is legal; nothing is dropped.
// Unpack order:
//   - mode 1 (4bpp): high nibble first.
//   - mode 2 (2bpp): bits [7:6] first.
//   - Each byte is popped once all its pixels are consumed.
// Mode 0 mapping:
//   - R=b[2:1], G=b[5:4], B=b[7:6].
//   - Each field is MSB-aligned into CHAN_BITS; the LSBs are zero-filled.
// Mode 1 mapping: the nibble indexes the palette; the entry is used as {B,G,R}.
// Mode 2 mapping: a 2-bit value v drives R=G=B=v, MSB-aligned with replicated LSBs (e.g. CHAN_BITS=4: v=2 gives 4'b1010).
// Timing:
//   - Source pixel k covers active cycles [k*2^hscale, (k+1)*2^hscale) counted from the active rising edge.
//   - RGB is registered and appears 1 cycle after the corresponding active cycle.
//   - While active=0 (registered), RGB is 0.
// Underflow:
//   - If a new pixel is due and no byte is available, hold the last colour and set underflow.
//   - The first byte must be present before active rises.
// Mid-line changes: changes to mode, hscale or vscale take effect only at the next row_pulse (sampled then).
// Reset mid-line: reset overrides everything within 1 cycle; start_read is never left asserted.
// stop_read: pulses 1 cycle after active falls.
//
// TESTING
// Reset:
//   - Stimulus: rst_n=0 for 2 cycles with byte_valid=1 and active=1.
//   - Required: RGB=0, start_read=0, flags=0, FIFO empty after release.
// 8bpp direct:
//   - Stimulus: frame_base=0x800000, mode0, hscale0, bytes 0xC6 then 0x30, then active.
//   - Required: start_read with addr 0x800000; first pixel R=3,G=0,B=3; second pixel R=0,G=3,B=0.
// 4bpp palette:
//   - Stimulus: pal[5]=6'b010110, pal[A]=6'b111111, byte 0x5A, hscale1.
//   - Required: 2 cycles of {B,G,R}=01,01,10, then 2 cycles of all 3s.
// Vertical stride:
//   - Stimulus: line_bytes=160, vscale1, 4 rows.
//   - Required: addr_out = 0x000,0x000,0x0A0,0x0A0.
//   - Extra: frame_pulse and row_pulse together -> addr_out=frame_base.
// Overflow:
//   - Stimulus: FIFO_DEPTH+1 bytes pushed with active=0.
//   - Required: overflow=1; the first FIFO_DEPTH bytes are displayed; the last byte is lost.
// Underflow:
//   - Stimulus: active rises with an empty FIFO after one pixel 0xFF.
//   - Required: colour held at R=G=B=3; underflow=1; the flag stays set through later row_pulses.

Source files
------------

// File: rtl/photo_pixel_pipe.sv
// Per-row flash line fetch, byte FIFO, colour-mode unpack, power-of-two
// pixel replication and registered RGB for the VGA output stage.
module photo_pixel_pipe #(
  parameter int ADDR_W     = 24,
  parameter int COL_W      = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int CHAN_BITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      frame_base,
  input  logic [COL_W-1:0]       line_bytes,
  input  logic [1:0]             mode,
  input  logic [1:0]             hscale,
  input  logic [1:0]             vscale,
  input  logic                   row_pulse,
  input  logic                   frame_pulse,
  input  logic                   active,
  input  logic                   pal_we,
  input  logic [3:0]             pal_addr,
  input  logic [3*CHAN_BITS-1:0] pal_data,
  output logic                   start_read,
  output logic [ADDR_W-1:0]      addr_out,
  output logic                   stop_read,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic [CHAN_BITS-1:0]   R,
  output logic [CHAN_BITS-1:0]   G,
  output logic [CHAN_BITS-1:0]   B,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int PX_W  = 3 * CHAN_BITS;

  // Byte stream: byte_in is taken in every cycle byte_valid=1; there is no
  // ready, so a byte arriving on a full FIFO (without a same-cycle pop) is lost.
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [PX_W-1:0]   pal [16];

  logic [1:0]        mode_r, hscale_r, sub, hcnt, rep_cnt;
  logic [ADDR_W-1:0] line_addr;
  logic              active_d;
  logic [PX_W-1:0]   last_px;

  logic [7:0]        head;
  logic              empty, full, last_sub, due, pop, push_ok;
  logic [1:0]        hmax, vmask, v2;
  logic [3:0]        nib;
  logic [PX_W-1:0]   px;

  function automatic logic [CHAN_BITS-1:0] zero_fill(input logic [1:0] v);
    zero_fill = '0;
    zero_fill[CHAN_BITS-1 -: 2] = v;
  endfunction

  function automatic logic [CHAN_BITS-1:0] rep_fill(input logic [1:0] v);
    rep_fill = '0;
    for (int i = 0; i < CHAN_BITS; i++)
      rep_fill[CHAN_BITS-1-i] = (i % 2 == 0) ? v[1] : v[0];
  endfunction

  always_comb begin
    head  = fifo_mem[rd_ptr];
    empty = (count == '0);
    full  = (count == CNT_W'(FIFO_DEPTH));
    case (hscale_r)
      2'd0:    hmax = 2'd0;
      2'd1:    hmax = 2'd1;
      default: hmax = 2'd3;
    endcase
    case (vscale)
      2'd0:    vmask = 2'd0;
      2'd1:    vmask = 2'd1;
      default: vmask = 2'd3;
    endcase
    case (mode_r)
      2'd1:    last_sub = (sub == 2'd1);
      2'd2:    last_sub = (sub == 2'd3);
      default: last_sub = 1'b1;
    endcase
    nib = sub[0] ? head[3:0] : head[7:4];
    case (sub)
      2'd0:    v2 = head[7:6];
      2'd1:    v2 = head[5:4];
      2'd2:    v2 = head[3:2];
      default: v2 = head[1:0];
    endcase
    case (mode_r)
      2'd1:    px = pal[nib];
      2'd2:    px = {rep_fill(v2), rep_fill(v2), rep_fill(v2)};
      default: px = {zero_fill(head[7:6]), zero_fill(head[5:4]), zero_fill(head[2:1])};
    endcase
    due     = active && !row_pulse && (hcnt == 2'd0);
    pop     = due && !empty && last_sub;
    push_ok = byte_valid && !row_pulse && (!full || pop);
  end

  // Storage arrays carry no reset; the palette is undefined until written.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= byte_in;
    if (pal_we)  pal[pal_addr]    <= pal_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mode_r     <= '0;
      hscale_r   <= '0;
      sub        <= '0;
      hcnt       <= '0;
      rep_cnt    <= '0;
      line_addr  <= '0;
      active_d   <= 1'b0;
      last_px    <= '0;
      start_read <= 1'b0;
      addr_out   <= '0;
      stop_read  <= 1'b0;
      R          <= '0;
      G          <= '0;
      B          <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      start_read <= 1'b0;
      active_d   <= active;
      stop_read  <= active_d && !active;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (byte_valid && !row_pulse && full && !pop) overflow <= 1'b1;

      if (!active) begin
        {B, G, R} <= '0;
        hcnt      <= 2'd0;
      end else begin
        hcnt <= (hcnt == hmax) ? 2'd0 : hcnt + 2'd1;
        if (due && !empty) begin
          {B, G, R} <= px;
          last_px   <= px;
          sub       <= last_sub ? 2'd0 : sub + 2'd1;
        end else begin
          {B, G, R} <= last_px;
          if (due) underflow <= 1'b1;
        end
      end

      if (frame_pulse) begin
        line_addr <= frame_base;
        rep_cnt   <= 2'd0;
      end

      // Row start flushes the FIFO and unpacker; assignments here win.
      if (row_pulse) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        sub        <= 2'd0;
        hcnt       <= 2'd0;
        mode_r     <= mode;
        hscale_r   <= hscale;
        start_read <= 1'b1;
        if (frame_pulse) begin
          addr_out <= frame_base;
        end else begin
          addr_out <= line_addr;
          if ((rep_cnt & vmask) == vmask) begin
            rep_cnt   <= 2'd0;
            line_addr <= line_addr + ADDR_W'(line_bytes);
          end else begin
            rep_cnt <= rep_cnt + 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_photo_pixel_pipe.sv
// Scoreboard bench for photo_pixel_pipe: expected {B,G,R} pixels are queued
// as stimulus is planned and compared against captured output per active cycle.
module tb_photo_pixel_pipe;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   frame_base;
  logic [10:0]   line_bytes;
  logic [1:0]    mode, hscale, vscale;
  logic          row_pulse, frame_pulse, active;
  logic          pal_we;
  logic [3:0]    pal_addr;
  logic [3*CB-1:0] pal_data;
  logic          start_read, stop_read;
  logic [23:0]   addr_out;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic [CB-1:0] R, G, B;
  logic          overflow, underflow;

  int vectors = 0;
  int miscompares = 0;
  logic [3*CB-1:0] exp_q[$];
  logic [3*CB-1:0] obs_q[$];

  photo_pixel_pipe dut (
    .clk(clk), .rst_n(rst_n), .frame_base(frame_base), .line_bytes(line_bytes),
    .mode(mode), .hscale(hscale), .vscale(vscale), .row_pulse(row_pulse),
    .frame_pulse(frame_pulse), .active(active), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .start_read(start_read),
    .addr_out(addr_out), .stop_read(stop_read), .byte_in(byte_in),
    .byte_valid(byte_valid), .R(R), .G(G), .B(B), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Mode 0 reference: {B,G,R} = {b[7:6], b[5:4], b[2:1]} for 2-bit channels.
  function automatic logic [5:0] map8(input logic [7:0] b);
    map8 = {b[7], b[6], b[5], b[4], b[2], b[1]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_only();
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
  endtask

  task automatic do_row(input logic frame, output logic sr, output logic [23:0] ad,
                        output logic sr_after);
    @(negedge clk); row_pulse = 1'b1; frame_pulse = frame;
    @(negedge clk); row_pulse = 1'b0; frame_pulse = 1'b0;
    sr = start_read; ad = addr_out;
    @(negedge clk); sr_after = start_read;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); byte_in = b; byte_valid = 1'b1;
  endtask

  task automatic end_push();
    @(negedge clk); byte_valid = 1'b0;
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [5:0] data);
    @(negedge clk); pal_we = 1'b1; pal_addr = idx; pal_data = data;
    @(negedge clk); pal_we = 1'b0;
  endtask

  task automatic run_active(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) obs_q.push_back({B, G, R});
      active = 1'b1;
    end
    @(negedge clk);
    obs_q.push_back({B, G, R});
    active = 1'b0;
  endtask

  task automatic test_reset();
    logic sr, sra; logic [23:0] ad;
    rst_n = 1'b0; byte_valid = 1'b1; active = 1'b1; byte_in = 8'hAA;
    idle(2);
    vectors++;
    if ({R, G, B, start_read, stop_read, overflow, underflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %b expected 0", {R, G, B, start_read, stop_read, overflow, underflow});
    end
    rst_n = 1'b1; byte_valid = 1'b0; active = 1'b0;
    idle(1);
    vectors++;
    if ({R, G, B, start_read, stop_read, overflow, underflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 0", {R, G, B, start_read, stop_read, overflow, underflow});
    end
    active = 1'b1;
    idle(1);
    active = 1'b0;
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_fifo_empty: got underflow=%b expected 1", underflow);
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clears_flag: got %b expected 0", underflow);
    end
    // Reset landing on the start_read cycle must drop it next cycle.
    @(negedge clk); row_pulse = 1'b1;
    @(negedge clk); row_pulse = 1'b0; rst_n = 1'b0;
    sr = start_read;
    @(negedge clk); rst_n = 1'b1;
    sra = start_read;
    ad = addr_out;
    vectors++;
    if (sr !== 1'b1 || sra !== 1'b0 || ad !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_midline: got sr=%b after=%b addr=%h expected 1 0 000000", sr, sra, ad);
    end
  endtask

  task automatic test_8bpp();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    frame_base = 24'h800000; mode = 2'd0; hscale = 2'd0; vscale = 2'd0;
    frame_only();
    do_row(1'b0, sr, ad, sra);
    vectors++;
    if (sr !== 1'b1 || ad !== 24'h800000 || sra !== 1'b0) begin
      miscompares++;
      $display("FAIL 8bpp_read: got sr=%b addr=%h after=%b expected 1 800000 0", sr, ad, sra);
    end
    push_byte(8'hC6); push_byte(8'h30); end_push();
    exp_q.push_back({2'd3, 2'd0, 2'd3});
    exp_q.push_back({2'd0, 2'd3, 2'd0});
    obs_q.delete();
    run_active(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL 8bpp_pixel: got %b expected %b", o, e);
      end
    end
    idle(1);
    vectors++;
    if (stop_read !== 1'b1 || {R, G, B} !== '0) begin
      miscompares++;
      $display("FAIL stop_read: got stop=%b rgb=%b expected 1 0", stop_read, {R, G, B});
    end
    idle(1);
    vectors++;
    if (stop_read !== 1'b0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_read_end: got stop=%b uf=%b expected 0 0", stop_read, underflow);
    end
  endtask

  task automatic test_palette();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    pal_write(4'h5, 6'b010110);
    pal_write(4'hA, 6'b111111);
    mode = 2'd1; hscale = 2'd1;
    do_row(1'b0, sr, ad, sra);
    push_byte(8'h5A); end_push();
    repeat (2) exp_q.push_back(6'b010110);
    repeat (2) exp_q.push_back(6'b111111);
    obs_q.delete();
    run_active(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL palette_pixel: got %b expected %b", o, e);
      end
    end
  endtask

  task automatic test_grey();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    logic [1:0] v;
    mode = 2'd2; hscale = 2'd0;
    do_row(1'b0, sr, ad, sra);
    push_byte(8'h1B); end_push();
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      exp_q.push_back({v, v, v});
    end
    obs_q.delete();
    run_active(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL grey_pixel: got %b expected %b", o, e);
      end
    end
  endtask

  task automatic test_vstride();
    logic sr, sra; logic [23:0] ad;
    logic [23:0] want [5];
    want = '{24'h000, 24'h000, 24'h0A0, 24'h0A0, 24'h140};
    frame_base = 24'h0; line_bytes = 11'd160; vscale = 2'd1;
    frame_only();
    for (int i = 0; i < 5; i++) begin
      do_row(1'b0, sr, ad, sra);
      vectors++;
      if (sr !== 1'b1 || ad !== want[i]) begin
        miscompares++;
        $display("FAIL vstride_row%0d: got sr=%b addr=%h expected 1 %h", i, sr, ad, want[i]);
      end
    end
    frame_base = 24'h123456;
    do_row(1'b1, sr, ad, sra);
    vectors++;
    if (sr !== 1'b1 || ad !== 24'h123456) begin
      miscompares++;
      $display("FAIL frame_row_same: got sr=%b addr=%h expected 1 123456", sr, ad);
    end
    do_row(1'b0, sr, ad, sra);
    vectors++;
    if (ad !== 24'h123456) begin
      miscompares++;
      $display("FAIL frame_row_next: got addr=%h expected 123456", ad);
    end
  endtask

  task automatic test_overflow();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    logic [7:0] bytes [5];
    bytes = '{8'hC6, 8'h30, 8'h06, 8'hFF, 8'h00};
    mode = 2'd0; hscale = 2'd0; vscale = 2'd0;
    do_row(1'b0, sr, ad, sra);
    for (int i = 0; i < 5; i++) begin
      push_byte(bytes[i]);
      if (i < 4) exp_q.push_back(map8(bytes[i]));
    end
    end_push();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag: got %b expected 1", overflow);
    end
    obs_q.delete();
    run_active(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL overflow_pixel: got %b expected %b", o, e);
      end
    end
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_no_uf: got %b expected 0", underflow);
    end
  endtask

  task automatic test_underflow();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    do_row(1'b0, sr, ad, sra);
    push_byte(8'hFF); end_push();
    repeat (3) exp_q.push_back(6'b111111);
    obs_q.delete();
    run_active(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL underflow_hold: got %b expected %b", o, e);
      end
    end
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_flag: got %b expected 1", underflow);
    end
    do_row(1'b0, sr, ad, sra);
    do_row(1'b0, sr, ad, sra);
    vectors++;
    if (underflow !== 1'b1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL flags_sticky: got uf=%b of=%b expected 1 1", underflow, overflow);
    end
  endtask

  task automatic test_hscale_clamp();
    logic sr, sra; logic [23:0] ad;
    logic [5:0] e, o;
    mode = 2'd3; hscale = 2'd3;
    do_row(1'b0, sr, ad, sra);
    push_byte(8'hC6); push_byte(8'h30); end_push();
    repeat (4) exp_q.push_back(map8(8'hC6));
    repeat (4) exp_q.push_back(map8(8'h30));
    obs_q.delete();
    run_active(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (o !== e) begin
        miscompares++;
        $display("FAIL hscale_clamp_pixel: got %b expected %b", o, e);
      end
    end
  endtask

  initial begin
    frame_base = '0; line_bytes = '0; mode = '0; hscale = '0; vscale = '0;
    row_pulse = 1'b0; frame_pulse = 1'b0; active = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    byte_in = '0; byte_valid = 1'b0; rst_n = 1'b0;
    test_reset();
    test_8bpp();
    test_palette();
    test_grey();
    test_vstride();
    test_overflow();
    test_underflow();
    test_hscale_clamp();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
